// File: rtl/spi_xfer_queue.sv
// Byte-queue front end for an SPI master: an 8-deep TX FIFO feeds one master transfer per byte,
// and each received byte is collected into an 8-deep RX FIFO, with sticky overflow/timeout flags.
module spi_xfer_queue #(
   parameter int DEPTH      = 8,
   parameter int AW         = 3,
   parameter int GAP_CYCLES = 4,
   parameter int TIMEOUT    = 4095
) (
   input  logic          clk_m,
   input  logic          rst,
   input  logic          run,
   input  logic          wr_en,
   input  logic [7:0]    wr_data,
   output logic          tx_full,
   output logic [AW:0]   tx_level,
   input  logic          rd_en,
   output logic [7:0]    rd_data,
   output logic          rx_empty,
   output logic [AW:0]   rx_level,
   output logic          active,
   output logic          rx_overflow,
   output logic          timeout_err,
   input  logic          clr_err,
   output logic          m_start,
   output logic [7:0]    m_tx_data,
   input  logic          m_busy,
   input  logic          m_done,
   input  logic [7:0]    m_rx_data
);

   localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
   localparam int GW = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES + 1);

   typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_DONE, GAP} state_t;

   state_t         state_q, state_d;
   logic [TW-1:0]  timer_q, timer_d;
   logic [GW-1:0]  gapCnt_q, gapCnt_d;

   logic [7:0]     txMem_q [DEPTH];
   logic [AW-1:0]  txWrPtr_q, txRdPtr_q;
   logic [AW:0]    txLevel_q;
   logic [7:0]     rxMem_q [DEPTH];
   logic [AW-1:0]  rxWrPtr_q, rxRdPtr_q;
   logic [AW:0]    rxLevel_q;
   logic [7:0]     txData_q;
   logic           rxOvf_q, timeoutErr_q;

   logic           txPush, txPop, rxPush, rxPop, rxFull, doneEvt, ovfEvt, toEvt;

   assign tx_full     = (txLevel_q == (AW+1)'(DEPTH));
   assign tx_level    = txLevel_q;
   assign rxFull      = (rxLevel_q == (AW+1)'(DEPTH));
   assign rx_empty    = (rxLevel_q == '0);
   assign rx_level    = rxLevel_q;
   assign rd_data     = rx_empty ? 8'h00 : rxMem_q[rxRdPtr_q];
   assign active      = (state_q != IDLE);
   assign m_start     = (state_q == LAUNCH);
   assign m_tx_data   = txData_q;
   assign rx_overflow = rxOvf_q;
   assign timeout_err = timeoutErr_q;

   // A full RX FIFO still accepts the received byte when the reader frees a slot in the same cycle.
   assign txPush  = wr_en && !tx_full;
   assign txPop   = (state_q == IDLE) && run && (txLevel_q != '0) && !m_busy;
   assign rxPop   = rd_en && !rx_empty;
   assign doneEvt = (state_q == WAIT_DONE) && m_done;
   assign rxPush  = doneEvt && (!rxFull || rd_en);
   assign ovfEvt  = doneEvt && rxFull && !rd_en;
   assign toEvt   = (state_q == WAIT_DONE) && !m_done && (timer_q == TW'(TIMEOUT - 1));

   always_ff @(posedge clk_m or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         timer_q  <= '0;
         gapCnt_q <= '0;
      end else begin
         state_q  <= state_d;
         timer_q  <= timer_d;
         gapCnt_q <= gapCnt_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      timer_d  = timer_q;
      gapCnt_d = gapCnt_q;
      unique case (state_q)
         IDLE: begin
            if (txPop) state_d = LAUNCH;
         end
         LAUNCH: begin
            timer_d = '0;
            state_d = WAIT_DONE;
         end
         WAIT_DONE: begin
            timer_d = timer_q + 1'b1;
            if (m_done || toEvt) begin
               gapCnt_d = '0;
               state_d  = GAP;
            end
         end
         GAP: begin
            // GAP always lasts at least one cycle, even when no idle gap is requested.
            if (int'(gapCnt_q) + 1 >= GAP_CYCLES) state_d = IDLE;
            else                                  gapCnt_d = gapCnt_q + 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_m) begin
      if (txPush) txMem_q[txWrPtr_q] <= wr_data;
      if (rxPush) rxMem_q[rxWrPtr_q] <= m_rx_data;
   end

   always_ff @(posedge clk_m or posedge rst) begin
      if (rst) begin
         txWrPtr_q    <= '0;
         txRdPtr_q    <= '0;
         txLevel_q    <= '0;
         rxWrPtr_q    <= '0;
         rxRdPtr_q    <= '0;
         rxLevel_q    <= '0;
         txData_q     <= 8'h00;
         rxOvf_q      <= 1'b0;
         timeoutErr_q <= 1'b0;
      end else begin
         if (txPush) txWrPtr_q <= txWrPtr_q + 1'b1;
         if (txPop) begin
            txRdPtr_q <= txRdPtr_q + 1'b1;
            txData_q  <= txMem_q[txRdPtr_q];
         end
         if (txPush && !txPop)      txLevel_q <= txLevel_q + 1'b1;
         else if (!txPush && txPop) txLevel_q <= txLevel_q - 1'b1;

         if (rxPush) rxWrPtr_q <= rxWrPtr_q + 1'b1;
         if (rxPop)  rxRdPtr_q <= rxRdPtr_q + 1'b1;
         if (rxPush && !rxPop)      rxLevel_q <= rxLevel_q + 1'b1;
         else if (!rxPush && rxPop) rxLevel_q <= rxLevel_q - 1'b1;

         // Error events take priority over a simultaneous clear.
         if (ovfEvt)       rxOvf_q <= 1'b1;
         else if (clr_err) rxOvf_q <= 1'b0;
         if (toEvt)        timeoutErr_q <= 1'b1;
         else if (clr_err) timeoutErr_q <= 1'b0;
      end
   end

endmodule

// File: tb/tb_spi_xfer_queue.sv
// Directed, self-checking bench for spi_xfer_queue with a simple SPI master model that
// answers each launched byte with (byte ^ 8'h99) after a programmable delay.
module tb_spi_xfer_queue;

   localparam int DEPTH      = 8;
   localparam int AW         = 3;
   localparam int GAP_CYCLES = 4;
   localparam int TIMEOUT    = 4095;

   logic          clk_m;
   logic          rst;
   logic          run;
   logic          wr_en;
   logic [7:0]    wr_data;
   logic          tx_full;
   logic [AW:0]   tx_level;
   logic          rd_en;
   logic [7:0]    rd_data;
   logic          rx_empty;
   logic [AW:0]   rx_level;
   logic          active;
   logic          rx_overflow;
   logic          timeout_err;
   logic          clr_err;
   logic          m_start;
   logic [7:0]    m_tx_data;
   logic          m_busy;
   logic          m_done;
   logic [7:0]    m_rx_data;

   int            checks;
   int            failures;
   int            masterDelay;
   logic          masterMute;
   logic [7:0]    mByte;

   typedef struct {
      logic        wrEn;
      logic [7:0]  wrData;
      logic [AW:0] expLevel;
      logic        expFull;
   } vec_t;

   vec_t          vecs [9];

   spi_xfer_queue #(
      .DEPTH(DEPTH), .AW(AW), .GAP_CYCLES(GAP_CYCLES), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk_m(clk_m), .rst(rst), .run(run),
      .wr_en(wr_en), .wr_data(wr_data), .tx_full(tx_full), .tx_level(tx_level),
      .rd_en(rd_en), .rd_data(rd_data), .rx_empty(rx_empty), .rx_level(rx_level),
      .active(active), .rx_overflow(rx_overflow), .timeout_err(timeout_err),
      .clr_err(clr_err), .m_start(m_start), .m_tx_data(m_tx_data),
      .m_busy(m_busy), .m_done(m_done), .m_rx_data(m_rx_data)
   );

   initial begin
      clk_m = 1'b0;
      forever #5 clk_m = ~clk_m;
   end

   // Master model: answers each unmuted launch with byte ^ 0x99 after masterDelay cycles.
   initial begin
      m_done    = 1'b0;
      m_busy    = 1'b0;
      m_rx_data = 8'h00;
      mByte     = 8'h00;
      forever begin
         @(negedge clk_m);
         if (m_start && !masterMute) begin
            mByte  = m_tx_data;
            m_busy = 1'b1;
            repeat (masterDelay - 1) @(negedge clk_m);
            m_done    = 1'b1;
            m_rx_data = mByte ^ 8'h99;
            @(negedge clk_m);
            m_done = 1'b0;
            m_busy = 1'b0;
         end
      end
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_m);
      #1;
   endtask

   task automatic applyStimulus(input logic we, input logic [7:0] wd, input logic re, input logic ce);
      wr_en   = we;
      wr_data = wd;
      rd_en   = re;
      clr_err = ce;
      tick();
      wr_en   = 1'b0;
      rd_en   = 1'b0;
      clr_err = 1'b0;
   endtask

   task automatic checkResetValues(input string tag);
      checkOutput({tag, "_tx_full"},     tx_full,     0);
      checkOutput({tag, "_tx_level"},    tx_level,    0);
      checkOutput({tag, "_rx_empty"},    rx_empty,    1);
      checkOutput({tag, "_rx_level"},    rx_level,    0);
      checkOutput({tag, "_rd_data"},     rd_data,     0);
      checkOutput({tag, "_active"},      active,      0);
      checkOutput({tag, "_m_start"},     m_start,     0);
      checkOutput({tag, "_m_tx_data"},   m_tx_data,   0);
      checkOutput({tag, "_rx_overflow"}, rx_overflow, 0);
      checkOutput({tag, "_timeout_err"}, timeout_err, 0);
   endtask

   task automatic waitStart(input string name, input int budget);
      int n = 0;
      while (!m_start && n < budget) begin
         tick();
         n++;
      end
      checkOutput(name, m_start, 1);
   endtask

   task automatic waitIdle(input string name, input int budget);
      int n = 0;
      while (active && n < budget) begin
         tick();
         n++;
      end
      checkOutput(name, active, 0);
   endtask

   task automatic waitRxLevel(input string name, input logic [AW:0] target, input int budget);
      int n = 0;
      while (rx_level != target && n < budget) begin
         tick();
         n++;
      end
      checkOutput(name, rx_level, target);
   endtask

   initial begin
      int pulses;
      int lastT;
      int starts;
      logic found;
      logic [7:0] expByte;

      checks      = 0;
      failures    = 0;
      masterDelay = 20;
      masterMute  = 1'b0;
      rst         = 1'b1;
      run         = 1'b0;
      wr_en       = 1'b0;
      wr_data     = 8'h00;
      rd_en       = 1'b0;
      clr_err     = 1'b0;

      for (int i = 0; i < 9; i++) begin
         vecs[i].wrEn     = 1'b1;
         vecs[i].wrData   = 8'(i + 1);
         vecs[i].expLevel = (i < 8) ? (AW+1)'(i + 1) : (AW+1)'(DEPTH);
         vecs[i].expFull  = (i >= 7);
      end

      repeat (3) tick();
      checkResetValues("reset");
      rst = 1'b0;
      tick();

      // Single byte: launch latency and returned data.
      run = 1'b1;
      applyStimulus(1'b1, 8'hA5, 1'b0, 1'b0);
      checkOutput("t1_no_start_yet", m_start, 0);
      checkOutput("t1_tx_level", tx_level, 1);
      tick();
      checkOutput("t1_m_start", m_start, 1);
      checkOutput("t1_m_tx_data", m_tx_data, 8'hA5);
      checkOutput("t1_active", active, 1);
      tick();
      checkOutput("t1_start_one_cycle", m_start, 0);
      waitRxLevel("t1_rx_level", 1, 100);
      checkOutput("t1_rd_data", rd_data, 8'h3C);
      checkOutput("t1_rx_empty", rx_empty, 0);
      waitIdle("t1_idle", 50);
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
      checkOutput("t1_rx_empty_after_pop", rx_empty, 1);
      checkOutput("t1_rd_data_empty", rd_data, 0);

      // Fill TX with run=0 from the vector table; the ninth write must be ignored.
      masterDelay = 3;
      run = 1'b0;
      for (int i = 0; i < 9; i++) begin
         applyStimulus(vecs[i].wrEn, vecs[i].wrData, 1'b0, 1'b0);
         checkOutput($sformatf("vec%0d_tx_level", i), tx_level, vecs[i].expLevel);
         checkOutput($sformatf("vec%0d_tx_full", i), tx_full, vecs[i].expFull);
      end
      run    = 1'b1;
      pulses = 0;
      lastT  = 0;
      for (int t = 0; t < 200; t++) begin
         tick();
         if (m_start) begin
            if (pulses < 8) checkOutput($sformatf("t2_byte%0d", pulses), m_tx_data, pulses + 1);
            if (pulses > 0) checkOutput($sformatf("t2_spacing%0d", pulses), (t - lastT) >= GAP_CYCLES + 1, 1);
            lastT = t;
            pulses++;
         end
      end
      checkOutput("t2_pulse_count", pulses, 8);
      checkOutput("t2_tx_level", tx_level, 0);
      checkOutput("t2_rx_level", rx_level, 8);
      checkOutput("t2_no_overflow", rx_overflow, 0);

      // RX full: a ninth received byte (0xEE ^ 0x99 = 0x77) is dropped.
      applyStimulus(1'b1, 8'hEE, 1'b0, 1'b0);
      tick();
      waitIdle("t3_idle", 60);
      checkOutput("t3_rx_overflow", rx_overflow, 1);
      checkOutput("t3_rx_level", rx_level, 8);
      checkOutput("t3_head", rd_data, 8'h98);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
      checkOutput("t3_overflow_cleared", rx_overflow, 0);

      // Same-cycle pop and push while RX is full.
      applyStimulus(1'b1, 8'h42, 1'b0, 1'b0);
      found = 1'b0;
      for (int n = 0; n < 100 && !found; n++) begin
         @(negedge clk_m);
         #1;
         if (m_done) found = 1'b1;
      end
      checkOutput("t6_done_seen", found, 1);
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      checkOutput("t6_rx_level", rx_level, 8);
      checkOutput("t6_no_overflow", rx_overflow, 0);
      for (int i = 0; i < 8; i++) begin
         expByte = (i < 7) ? (8'(i + 2) ^ 8'h99) : 8'hDB;
         checkOutput($sformatf("t6_drain%0d", i), rd_data, expByte);
         applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
      end
      checkOutput("t6_rx_empty", rx_empty, 1);
      waitIdle("t6_idle", 50);

      // Timeout on a silent master, with clr_err colliding with the set.
      masterMute = 1'b1;
      applyStimulus(1'b1, 8'h11, 1'b0, 1'b0);
      applyStimulus(1'b1, 8'h22, 1'b0, 1'b0);
      waitStart("t4_start", 20);
      checkOutput("t4_m_tx_data", m_tx_data, 8'h11);
      repeat (TIMEOUT) tick();
      checkOutput("t4_not_yet", timeout_err, 0);
      checkOutput("t4_still_waiting", active, 1);
      clr_err = 1'b1;
      tick();
      clr_err = 1'b0;
      checkOutput("t4_timeout_set_wins", timeout_err, 1);
      masterMute = 1'b0;
      repeat (3) tick();
      checkOutput("t4_in_gap", active, 1);
      tick();
      checkOutput("t4_back_idle", active, 0);
      tick();
      checkOutput("t4_next_start", m_start, 1);
      checkOutput("t4_next_byte", m_tx_data, 8'h22);
      waitRxLevel("t4_rx_level", 1, 100);
      checkOutput("t4_rd_data", rd_data, 8'hBB);
      checkOutput("t4_sticky", timeout_err, 1);
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b1);
      checkOutput("t4_cleared", timeout_err, 0);
      checkOutput("t4_rx_empty", rx_empty, 1);
      waitIdle("t4_idle", 50);

      // Asynchronous reset during WAIT_DONE with bytes queued; the late m_done is ignored.
      masterDelay = 30;
      run = 1'b0;
      applyStimulus(1'b1, 8'h31, 1'b0, 1'b0);
      applyStimulus(1'b1, 8'h32, 1'b0, 1'b0);
      applyStimulus(1'b1, 8'h33, 1'b0, 1'b0);
      checkOutput("t5_tx_level", tx_level, 3);
      run = 1'b1;
      waitStart("t5_start", 20);
      repeat (3) tick();
      rst = 1'b1;
      #1;
      checkResetValues("t5_async");
      tick();
      rst = 1'b0;
      starts = 0;
      for (int t = 0; t < 40; t++) begin
         tick();
         if (m_start) starts++;
      end
      checkOutput("t5_no_launch", starts, 0);
      checkOutput("t5_rx_level", rx_level, 0);
      checkOutput("t5_rx_empty", rx_empty, 1);
      checkOutput("t5_active", active, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/spi_xfer_queue.md
Name: spi_xfer_queue

Overview:
- Byte-queue front end that sits directly upstream of the SPI master.
- The processor writes TX bytes into an 8-deep FIFO. The block launches one master transfer per byte, then collects each received byte into an 8-deep RX FIFO for the processor to read.
- It decouples processor writes from SPI timing. It also reports overflow and timeout errors.

Parameters:
- DEPTH, 8, entries per FIFO; power of two, minimum 2.
- AW, 3, log2(DEPTH).
- GAP_CYCLES, 4, idle clk_m cycles enforced between consecutive m_start pulses (0 allowed).
- TIMEOUT, 4095, clk_m cycles allowed from m_start to m_done before abort.

Ports:
- clk_m  in  1  system clock; all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- run  in  1  1 = launching new transfers permitted.
- wr_en  in  1  push wr_data into TX FIFO.
- wr_data  in  8  TX byte.
- tx_full  out  1  TX FIFO full.
- tx_level  out  AW+1  TX occupancy, 0..DEPTH.
- rd_en  in  1  pop RX FIFO head.
- rd_data  out  8  RX FIFO head (first-word fall-through).
- rx_empty  out  1  RX FIFO empty.
- rx_level  out  AW+1  RX occupancy.
- active  out  1  a transfer is in flight (LAUNCH..GAP).
- rx_overflow  out  1  sticky; a received byte was dropped.
- timeout_err  out  1  sticky; master failed to complete.
- clr_err  in  1  clears both sticky flags.
- m_start  out  1  one-cycle launch pulse to SPI master.
- m_tx_data  out  8  byte to shift out; stable from m_start until m_done.
- m_busy  in  1  master busy.
- m_done  in  1  one-cycle pulse: transfer finished, m_rx_data valid.
- m_rx_data  in  8  received byte.

Behaviour:
- Reset (async, any time, including mid-transfer):
  - state = IDLE; both FIFOs emptied.
  - tx_full=0, tx_level=0, rx_empty=1, rx_level=0, rd_data=0, active=0.
  - m_start=0, m_tx_data=0, rx_overflow=0, timeout_err=0.
  - Counters cleared.
- TX FIFO:
  - wr_en while tx_full is ignored; contents unchanged, no error.
  - Push and pop in the same cycle: level unchanged.
  - Pointers wrap modulo DEPTH.
- RX FIFO:
  - rd_data always equals the head entry, and is 0 when empty.
  - rd_en while empty is ignored.
  - A push (from m_done) and rd_en in the same cycle are both honoured.
- FSM states: IDLE, LAUNCH, WAIT_DONE, GAP.
  - IDLE: when run=1, tx_level>0 and m_busy=0 → pop TX head into m_tx_data; go to LAUNCH.
  - LAUNCH: m_start=1 for exactly this cycle; timeout counter cleared; → WAIT_DONE.
  - WAIT_DONE: the counter increments each cycle.
    - On m_done=1: capture m_rx_data. Push it if RX not full (or if rd_en pops the same cycle). Otherwise drop it and set rx_overflow. → GAP.
    - If the counter reaches TIMEOUT with no m_done: set timeout_err, discard the byte, → GAP.
  - GAP: count GAP_CYCLES cycles → IDLE. With GAP_CYCLES=0, go straight to IDLE the next cycle.
- Latency: byte written to an empty TX FIFO with run=1 and m_busy=0 → m_start asserted 2 cycles later (IDLE pop, LAUNCH).
- run deasserted mid-transfer: the current transfer completes normally; no new launch until run=1.
- m_done outside WAIT_DONE is ignored.
- clr_err:
  - Clears both sticky flags.
  - If an error-setting event occurs in the same cycle, set wins.
- active=1 in LAUNCH, WAIT_DONE and GAP.
- Level counters are AW+1 bits and saturate logically at DEPTH (never exceeded by construction).

Test Plan:
- Reset, run=1, write 0xA5; master model returns 0x3C after 20 cycles → m_start 2 cycles after the write with m_tx_data=0xA5; rd_data=0x3C, rx_level=1, rx_empty=0.
- Write 9 bytes 0x01..0x09 with run=0 → tx_full=1 after the 8th write, 9th ignored, tx_level=8; set run=1 → exactly 8 m_start pulses with 0x01..0x08 in order, each at least GAP_CYCLES+1 cycles apart.
- Fill the RX FIFO with 8 transfers without reading, then run a 9th transfer returning 0x77 → byte dropped, rx_overflow=1, rx_level=8; clr_err → rx_overflow=0.
- Master model never pulses m_done → timeout_err=1 exactly TIMEOUT cycles after WAIT_DONE entry; FSM returns to IDLE after the gap; next queued byte launches.
- Assert rst during WAIT_DONE with 3 bytes queued → all outputs at reset values in the same cycle; a later m_done is ignored and rx_level stays 0.
- Same-cycle rd_en and m_done with RX full (8 entries) → head popped, new byte pushed, rx_level stays 8, rx_overflow stays 0.
